// File: rtl/cache_write_buffer.sv
// Write-back buffer between the L1 cache and line-granular memory: queues dirty
// evictions, drains them when the bus is idle, and serves reads from the queue or
// memory. Optional in-place write merging is enabled by defining WB_MERGE_EN.
module cache_write_buffer #(
  parameter int LINE_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     c_is_input_valid,
  input  logic [31:0]              c_addr,
  input  logic                     c_mem_read,
  input  logic                     c_mem_write,
  input  logic [8*LINE_SIZE-1:0]   c_din,
  output logic                     c_is_ready,
  output logic                     c_is_output_valid,
  output logic [8*LINE_SIZE-1:0]   c_dout,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     m_is_input_valid,
  output logic                     m_mem_read,
  output logic                     m_mem_write,
  output logic [31:0]              m_addr,
  output logic [8*LINE_SIZE-1:0]   m_din,
  input  logic                     m_is_output_valid,
  input  logic [8*LINE_SIZE-1:0]   m_dout,
  input  logic                     m_mem_ready
);

  localparam int W  = 8 * LINE_SIZE;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [DEPTH-1:0] valid_q;
  logic [31:4]     addr_q [DEPTH];
  logic [W-1:0]    data_q [DEPTH];
  logic [W-1:0]    c_dout_q;
  logic            c_valid_q;

  logic            ready, wr_req, rd_req, hit, rd_hit, rd_miss, drain, enq, merge;
  logic [PW-1:0]   hit_idx, idx;
  logic            unused_low_addr;

  assign unused_low_addr = ^c_addr[3:0];

  // Walk entries oldest to youngest so the youngest matching line wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head_q;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && addr_q[idx] == c_addr[31:4]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign ready   = reset && (state_q == IDLE) && (count_q < CW'(DEPTH));
  assign wr_req  = c_is_input_valid && c_mem_write;
  assign rd_req  = c_is_input_valid && c_mem_read && !c_mem_write;
  assign rd_hit  = ready && rd_req && hit;
  assign rd_miss = ready && rd_req && !hit && m_mem_ready;
  assign drain   = (state_q == IDLE) && (count_q != '0) && m_mem_ready && !rd_miss;

`ifdef WB_MERGE_EN
  // A matching line may be rewritten in place unless it is the head leaving this cycle.
  assign merge = reset && (state_q == IDLE) && wr_req && hit && !(drain && hit_idx == head_q);
  assign enq   = ready && wr_req && !merge;
`else
  assign merge = 1'b0;
  assign enq   = ready && wr_req;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      c_dout_q  <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_valid_q <= rd_hit;
      if (rd_hit) c_dout_q <= data_q[hit_idx];
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: line storage carries no reset; valid_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= c_addr[31:4];
      data_q[tail_q] <= c_din;
    end
    if (merge) data_q[hit_idx] <= c_din;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_miss) state_d = RD_WAIT;
      RD_WAIT: if (m_is_output_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_is_ready        = ready;
    c_is_output_valid = c_valid_q;
    c_dout            = c_dout_q;
    m_is_input_valid  = rd_miss || drain;
    m_mem_read        = rd_miss;
    m_mem_write       = drain;
    m_addr            = '0;
    m_din             = '0;
    if (state_q == RD_WAIT) begin
      c_is_output_valid = m_is_output_valid;
      c_dout            = m_dout;
    end
    if (rd_miss) begin
      m_addr = {c_addr[31:4], 4'b0};
    end else if (drain) begin
      m_addr = {addr_q[head_q], 4'b0};
      m_din  = data_q[head_q];
    end
  end

  assign wb_count = count_q;

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Write-back buffer between the L1 `Cache` and the line-granular data memory. It absorbs dirty-line evictions from the cache in one cycle, so the cache does not wait on the 50-cycle memory write. It drains queued lines to memory when the bus is idle and serves line reads either from the buffer (when the address matches a queued line) or by forwarding them to memory.

## Interface
- `LINE_SIZE`, 16: line size in bytes; data ports are `8*LINE_SIZE` bits wide.
- `DEPTH`, 4: number of line entries; must be a power of two, ≥2.

- `clk` in 1: the single clock.
- `reset` in 1: reset, asynchronous, active-low (asserted at 0).
- `c_is_input_valid` in 1: cache request strobe.
- `c_addr` in 32: line address; bits `[3:0]` are ignored and treated as 0.
- `c_mem_read` in 1: read request (line fill).
- `c_mem_write` in 1: write request (eviction).
- `c_din` in `8*LINE_SIZE`: eviction data.
- `c_is_ready` out 1: the buffer accepts a request this cycle.
- `c_is_output_valid` out 1: `c_dout` holds the read line (one-cycle pulse).
- `c_dout` out `8*LINE_SIZE`: read line.
- `wb_count` out `$clog2(DEPTH)+1`: occupied entries.
- `m_is_input_valid`, `m_mem_read`, `m_mem_write` out 1: memory request.
- `m_addr` out 32: line address to memory.
- `m_din` out `8*LINE_SIZE`: line to memory.
- `m_is_output_valid` in 1: memory read data valid.
- `m_dout` in `8*LINE_SIZE`: memory read data.
- `m_mem_ready` in 1: memory accepts a request.

## Operation
- Storage: circular FIFO of `{valid, addr[31:4], data}`, with head/tail pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`. `wb_count` is the registered occupancy.
- FSM states:
  - `IDLE` → `RD_WAIT` when a read miss is issued to memory.
  - `RD_WAIT` → `IDLE` in the cycle after `m_is_output_valid`.
- `c_is_ready = reset && state==IDLE && wb_count<DEPTH`, computed from registered values only. A pop in the same cycle does not free a slot for a write in that cycle.
- Both `c_mem_read` and `c_mem_write` set together: treat as a write.
- Accepted write: enqueue at tail and increment `wb_count`.
- Accepted read, lookup over valid entries, youngest match wins:
  - Hit: register the entry data into `c_dout` and pulse `c_is_output_valid` the next cycle. No memory access.
  - Miss: drive `m_is_input_valid=1`, `m_mem_read=1`, `m_addr={c_addr[31:4],4'b0}` combinationally in the same cycle (requires `m_mem_ready`; otherwise `c_is_ready` is held low and the cache retries). Go to `RD_WAIT`.
  - Miss ordering is safe: no queued line aliases the address.
- `RD_WAIT`: `c_dout=m_dout` and `c_is_output_valid=m_is_output_valid` combinationally. No drain is issued in this state.
- Drain: in `IDLE` with `wb_count>0`, `m_mem_ready=1`, and no accepted read miss this cycle:
  - issue `m_mem_write=1`, `m_addr={head.addr,4'b0}`, `m_din=head.data`;
  - pop the head at issue (decrement `wb_count`, advance head).
- Priority: a read miss beats a drain. A write enqueue and a drain pop may occur in the same cycle; `wb_count` is then unchanged.
- A read that hits the head entry while that entry is being popped is still served from the buffer, with the data sampled before the pop.

## Timing
- Reset (asynchronous, while `reset`=0):
  - FIFO emptied, pointers 0, `wb_count`=0, state `IDLE`.
  - `c_dout`=0, `c_is_output_valid`=0, `c_is_ready`=0.
  - All memory-side outputs 0.
- Reset asserted in `RD_WAIT`: the outstanding memory read is abandoned and its return ignored. Queued lines are lost.
- Write acceptance: 0 cycles of stall when not full; the entry becomes visible to lookups and to drain in the next cycle.
- Read hit: data at N+1 for a request at cycle N.
- Read miss: memory latency plus 0 (combinational return).
- Drain: one memory write per `m_mem_ready` window; the head is popped in the issue cycle.
- Memory-side strobes are single-cycle and combinational from registered state and cache inputs.

## Configuration
- `WB_MERGE_EN` defined: a write whose address matches a valid queued entry other than the head being issued this cycle overwrites that entry's data in place. No enqueue, `wb_count` unchanged, and the write is accepted even when full.
- `WB_MERGE_EN` undefined: every write enqueues a new entry. Reads return the youngest match.

## Test plan
- Reset, then write line `0x100`=`A` → `wb_count`=1. With `m_mem_ready`=1, the next cycle shows `m_mem_write`=1, `m_addr`=`0x100`, `m_din`=`A`, then `wb_count`=0.
- With `m_mem_ready`=0, write `0x000`,`0x010`,`0x020`,`0x030` → `wb_count`=4 and `c_is_ready`=0. A 5th write is refused. Release ready → memory writes occur in order `0x000`..`0x030`.
- Queue `0x200`=`B`, then read `0x204` → `c_is_output_valid` pulse with `c_dout`=`B` one cycle later and no `m_mem_read`.
- With 2 lines queued, read miss `0x300` → `m_mem_read` is issued before any drain. `c_dout`=`m_dout` on `m_is_output_valid`, then draining resumes.
- With `WB_MERGE_EN`: with `m_mem_ready`=0, write `0x100`=`A`, then `0x100`=`C` → `wb_count`=1 and the drained data is `C`. Without the macro → `wb_count`=2 and a read of `0x100` returns `C`.
- Pull `reset` low during `RD_WAIT` → all outputs go to 0 immediately and `wb_count`=0. A later `m_is_output_valid` produces no `c_is_output_valid`.
